// File: rtl/mu_dest_filter_if.sv
// Bus bundle for mu_dest_filter: local MU broadcast (A), remote return path (B)
// and the write port into the cell's position cache.
interface mu_dest_filter_if #(
  parameter int GCID_W = 4,
  parameter int POS_W  = 27,
  parameter int ELEM_W = 2
);
  logic                 i_a_valid;
  logic [3*GCID_W-1:0]  i_a_gcid;
  logic [POS_W-1:0]     i_a_pos;
  logic [ELEM_W-1:0]    i_a_element;
  logic                 i_b_valid;
  logic [3*GCID_W-1:0]  i_b_gcid;
  logic [POS_W-1:0]     i_b_pos;
  logic [ELEM_W-1:0]    i_b_element;
  logic                 o_wr_en;
  logic [POS_W-1:0]     o_wr_pos;
  logic [ELEM_W-1:0]    o_wr_element;

  modport master (
    output i_a_valid, i_a_gcid, i_a_pos, i_a_element,
    output i_b_valid, i_b_gcid, i_b_pos, i_b_element,
    input  o_wr_en, o_wr_pos, o_wr_element
  );

  modport slave (
    input  i_a_valid, i_a_gcid, i_a_pos, i_a_element,
    input  i_b_valid, i_b_gcid, i_b_pos, i_b_element,
    output o_wr_en, o_wr_pos, o_wr_element
  );
endinterface

// File: rtl/mu_dest_filter.sv
// Motion-update write-back filter: queues packets addressed to this cell and writes them
// one per cycle into the position cache. MU_FILTER_STATS_EN adds o_rx_count/o_drop_count.
module mu_dest_filter #(
  parameter int GLOBAL_CELL_ID_WIDTH = 4,
  parameter int OFFSET_STRUCT_WIDTH  = 27,
  parameter int ELEMENT_WIDTH        = 2,
  parameter int PARTICLE_ID_WIDTH    = 7,
  parameter int GCELL_X              = 0,
  parameter int GCELL_Y              = 0,
  parameter int GCELL_Z              = 0,
  parameter int FIFO_DEPTH           = 8,
  parameter int MAX_PARTICLES        = 99
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_bcast_done,
  mu_dest_filter_if.slave              bus,
  output logic                         o_working,
  output logic                         o_drained,
  output logic                         o_overflow,
  output logic                         o_cell_full,
  output logic                         o_stray,
`ifdef MU_FILTER_STATS_EN
  output logic [PARTICLE_ID_WIDTH-1:0] o_rx_count,
  output logic [PARTICLE_ID_WIDTH-1:0] o_drop_count,
`endif
  output logic [PARTICLE_ID_WIDTH-1:0] o_wr_count
);
  localparam int GW    = GLOBAL_CELL_ID_WIDTH;
  localparam int PW    = OFFSET_STRUCT_WIDTH;
  localparam int EW    = ELEMENT_WIDTH;
  localparam int IW    = PARTICLE_ID_WIDTH;
  localparam int ENT_W = PW + EW;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3*GW-1:0] OWN_GCID = {GW'(GCELL_Z), GW'(GCELL_Y), GW'(GCELL_X)};
  localparam logic [IW-1:0]   MAX_CNT  = IW'(MAX_PARTICLES);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;
  state_t state;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt;

  logic             active, a_match, b_match, push_a, push_b;
  logic             pop_fifo, byp, take, drop, at_cap;
  logic [CNT_W-1:0] free, n_push, n_store;
  logic [ENT_W-1:0] ent_a, ent_b, item0, out_ent;

  // Free slots are counted after this cycle's pop. An empty FIFO lets the first
  // accepted packet bypass straight to the write port for single-cycle latency.
  always_comb begin
    active   = (state == S_COLLECT) || (state == S_DRAIN);
    a_match  = active && bus.i_a_valid && (bus.i_a_gcid == OWN_GCID);
    b_match  = active && bus.i_b_valid && (bus.i_b_gcid == OWN_GCID);
    pop_fifo = active && (cnt != '0);
    free     = CNT_W'(FIFO_DEPTH) - cnt + CNT_W'(pop_fifo);
    push_a   = a_match && (free != '0);
    push_b   = b_match && (free > CNT_W'(push_a));
    drop     = (a_match && !push_a) || (b_match && !push_b);
    byp      = active && (cnt == '0) && (push_a || push_b);
    take     = pop_fifo || byp;
    ent_a    = {bus.i_a_pos, bus.i_a_element};
    ent_b    = {bus.i_b_pos, bus.i_b_element};
    item0    = push_a ? ent_a : ent_b;
    out_ent  = pop_fifo ? mem[rd_ptr] : item0;
    n_push   = CNT_W'(push_a) + CNT_W'(push_b);
    n_store  = n_push - CNT_W'(byp);
    at_cap   = (o_wr_count == MAX_CNT);
  end

  always_ff @(posedge clk) begin
    if (byp) begin
      if (push_a && push_b) mem[wr_ptr] <= ent_b;
    end else begin
      if (push_a || push_b) mem[wr_ptr] <= item0;
      if (push_a && push_b) mem[wr_ptr + PTR_W'(1)] <= ent_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      cnt              <= '0;
      o_working        <= 1'b0;
      o_drained        <= 1'b0;
      o_overflow       <= 1'b0;
      o_cell_full      <= 1'b0;
      o_stray          <= 1'b0;
      o_wr_count       <= '0;
      bus.o_wr_en      <= 1'b0;
      bus.o_wr_pos     <= '0;
      bus.o_wr_element <= '0;
    end else begin
      bus.o_wr_en <= 1'b0;
      o_drained   <= 1'b0;
      if (!active && (bus.i_a_valid || bus.i_b_valid)) o_stray <= 1'b1;
      if (pop_fifo) rd_ptr <= rd_ptr + PTR_W'(1);
      wr_ptr <= wr_ptr + PTR_W'(n_store);
      cnt    <= cnt + n_store - CNT_W'(pop_fifo);
      if (drop) o_overflow <= 1'b1;
      if (take) begin
        if (at_cap) begin
          o_cell_full <= 1'b1;
        end else begin
          bus.o_wr_en      <= 1'b1;
          bus.o_wr_pos     <= out_ent[ENT_W-1:EW];
          bus.o_wr_element <= out_ent[EW-1:0];
          o_wr_count       <= o_wr_count + IW'(1);
        end
      end
      case (state)
        S_IDLE: if (i_start) begin
          state       <= S_COLLECT;
          o_working   <= 1'b1;
          o_wr_count  <= '0;
          o_overflow  <= 1'b0;
          o_cell_full <= 1'b0;
          o_stray     <= 1'b0;
        end
        S_COLLECT: if (i_bcast_done) state <= S_DRAIN;
        S_DRAIN: if ((cnt == '0) && !take) begin
          state     <= S_DONE;
          o_working <= 1'b0;
          o_drained <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MU_FILTER_STATS_EN
  function automatic logic [IW-1:0] sat_add(input logic [IW-1:0] a, input logic [1:0] b);
    logic [IW:0] s;
    s = {1'b0, a} + (IW + 1)'(b);
    return s[IW] ? '1 : s[IW-1:0];
  endfunction

  logic [1:0] n_rx, n_drop;
  assign n_rx   = 2'(a_match) + 2'(b_match);
  assign n_drop = 2'(a_match && !push_a) + 2'(b_match && !push_b) + 2'(take && at_cap);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rx_count   <= '0;
      o_drop_count <= '0;
    end else if (state == S_IDLE && i_start) begin
      o_rx_count   <= '0;
      o_drop_count <= '0;
    end else begin
      o_rx_count   <= sat_add(o_rx_count, n_rx);
      o_drop_count <= sat_add(o_drop_count, n_drop);
    end
  end
`endif
endmodule

// File: tb/tb_mu_dest_filter.sv
// Scoreboard bench for mu_dest_filter: accepted packets are queued when driven and
// matched against every o_wr_en beat in order.
module tb_mu_dest_filter;
  localparam int GW    = 4;
  localparam int PW    = 27;
  localparam int EW    = 2;
  localparam int IW    = 7;
  localparam int DEPTH = 8;
  localparam int MAXP  = 20;
  localparam int DW    = PW + EW;
  localparam logic [3*GW-1:0] OWN   = 12'h321;
  localparam logic [3*GW-1:0] OTHER = 12'h322;

  logic clk = 1'b0;
  logic rst, i_start, i_bcast_done;
  logic o_working, o_drained, o_overflow, o_cell_full, o_stray;
  logic [IW-1:0] o_wr_count;
`ifdef MU_FILTER_STATS_EN
  logic [IW-1:0] o_rx_count, o_drop_count;
`endif

  mu_dest_filter_if #(.GCID_W(GW), .POS_W(PW), .ELEM_W(EW)) bus ();

  mu_dest_filter #(
    .GLOBAL_CELL_ID_WIDTH(GW), .OFFSET_STRUCT_WIDTH(PW), .ELEMENT_WIDTH(EW),
    .PARTICLE_ID_WIDTH(IW), .GCELL_X(1), .GCELL_Y(2), .GCELL_Z(3),
    .FIFO_DEPTH(DEPTH), .MAX_PARTICLES(MAXP)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_bcast_done(i_bcast_done),
    .bus(bus), .o_working(o_working), .o_drained(o_drained),
    .o_overflow(o_overflow), .o_cell_full(o_cell_full), .o_stray(o_stray),
`ifdef MU_FILTER_STATS_EN
    .o_rx_count(o_rx_count), .o_drop_count(o_drop_count),
`endif
    .o_wr_count(o_wr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: occupancy of the match queue and per-phase expectations.
  logic [DW-1:0] exp_q [$];
  bit mdl_active = 0;
  int occ = 0;
  int n_acc = 0;
  bit exp_ovf = 0;
  bit exp_full = 0;
  bit exp_stray = 0;

  function automatic logic [DW-1:0] mk(input int pos, input int elem);
    return {PW'(pos), EW'(elem)};
  endfunction

  task automatic accept(input logic [DW-1:0] d);
    n_acc++;
    if (n_acc <= MAXP) exp_q.push_back(d);
    else exp_full = 1;
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (bus.o_wr_en === 1'b1) begin
      check("working_on_wr", o_working, 1'b1);
      if (exp_q.size() == 0) begin
        check("wr_unexpected", bus.o_wr_en, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", {bus.o_wr_pos, bus.o_wr_element}, e);
      end
    end
    if (o_drained === 1'b1) check("working_at_drain", o_working, 1'b0);
  end

  task automatic step(input bit av, input logic [3*GW-1:0] ag, input logic [DW-1:0] ad,
                      input bit bv, input logic [3*GW-1:0] bg, input logic [DW-1:0] bd,
                      input bit st, input bit fin);
    int lim, acc;
    @(negedge clk);
    #1;
    bus.i_a_valid = av; bus.i_a_gcid = ag; bus.i_a_pos = ad[DW-1:EW]; bus.i_a_element = ad[EW-1:0];
    bus.i_b_valid = bv; bus.i_b_gcid = bg; bus.i_b_pos = bd[DW-1:EW]; bus.i_b_element = bd[EW-1:0];
    i_start = st;
    i_bcast_done = fin;
    if (mdl_active) begin
      acc = 0;
      lim = DEPTH - occ + ((occ > 0) ? 1 : 0);
      if (av && ag == OWN) begin
        if (acc < lim) begin accept(ad); acc++; end else exp_ovf = 1;
      end
      if (bv && bg == OWN) begin
        if (acc < lim) begin accept(bd); acc++; end else exp_ovf = 1;
      end
      occ = occ + acc;
      if (occ > 0) occ--;
    end else begin
      if (av || bv) exp_stray = 1;
      if (st) begin
        mdl_active = 1; occ = 0; n_acc = 0;
        exp_ovf = 0; exp_full = 0; exp_stray = 0;
      end
    end
  endtask

  task automatic idle();
    step(0, '0, '0, 0, '0, '0, 0, 0);
  endtask

  task automatic finish_phase(input string tag);
    bit seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      idle();
      if (o_drained === 1'b1) seen = 1;
    end
    check({tag, "_drained"}, seen, 1'b1);
    mdl_active = 0;
    check({tag, "_wr_count"}, o_wr_count, (n_acc < MAXP) ? n_acc : MAXP);
    check({tag, "_overflow"}, o_overflow, exp_ovf);
    check({tag, "_cell_full"}, o_cell_full, exp_full);
    check({tag, "_working"}, o_working, 1'b0);
    check({tag, "_sb_left"}, exp_q.size(), 0);
    idle();
    check({tag, "_drain_pulse"}, o_drained, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_bcast_done = 1'b0;
    bus.i_a_valid = 1'b0; bus.i_a_gcid = '0; bus.i_a_pos = '0; bus.i_a_element = '0;
    bus.i_b_valid = 1'b0; bus.i_b_gcid = '0; bus.i_b_pos = '0; bus.i_b_element = '0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", bus.o_wr_en, 1'b0);
    check("rst_wr_pos", {bus.o_wr_pos, bus.o_wr_element}, '0);
    check("rst_flags", {o_working, o_drained, o_overflow, o_cell_full, o_stray}, 5'b0);
    check("rst_wr_count", o_wr_count, '0);
    #1 rst = 1'b0;

    // Stray packet in IDLE, then single match with one-cycle latency.
    step(1, OWN, mk(5, 0), 0, '0, '0, 0, 0);
    idle();
    check("stray_set", o_stray, 1'b1);
    step(0, '0, '0, 0, '0, '0, 1, 0);
    step(1, OWN, mk('h123, 1), 0, '0, '0, 0, 0);
    check("single_working", o_working, 1'b1);
    check("single_stray_clr", o_stray, 1'b0);
    @(posedge clk);
    #1;
    check("single_lat_en", bus.o_wr_en, 1'b1);
    check("single_lat_pos", bus.o_wr_pos, PW'('h123));
    step(0, '0, '0, 0, '0, '0, 0, 1);
    finish_phase("single");

    // Dual push, last pair arriving together with i_bcast_done.
    step(0, '0, '0, 0, '0, '0, 1, 0);
    for (int k = 0; k < 3; k++)
      step(1, OWN, mk('h100 + k, 1), 1, OWN, mk('h200 + k, 2), 0, (k == 2));
    finish_phase("dual");

    // Non-matching traffic only.
    step(0, '0, '0, 0, '0, '0, 1, 0);
    for (int k = 0; k < 10; k++) step(0, '0, '0, 1, OTHER, mk(k, 3), 0, 0);
    step(0, '0, '0, 0, '0, '0, 0, 1);
    finish_phase("nomatch");

    // Sustained dual push until the queue fills and B starts dropping.
    step(0, '0, '0, 0, '0, '0, 1, 0);
    for (int k = 0; k < 10; k++)
      step(1, OWN, mk('h300 + k, 0), 1, OWN, mk('h400 + k, 1), 0, 0);
    step(0, '0, '0, 0, '0, '0, 0, 1);
    finish_phase("overflow");
    check("overflow_flag", o_overflow, 1'b1);
`ifdef MU_FILTER_STATS_EN
    check("stats_rx", o_rx_count, 20);
    check("stats_drop", o_drop_count, 2);
`endif

    // More matches than the cell can hold.
    step(0, '0, '0, 0, '0, '0, 1, 0);
    for (int k = 0; k < MAXP + 4; k++) step(1, OWN, mk('h500 + k, 2), 0, '0, '0, 0, 0);
    step(0, '0, '0, 0, '0, '0, 0, 1);
    finish_phase("capacity");
    check("capacity_flag", o_cell_full, 1'b1);

    // Reset while DRAIN still holds three queued packets.
    step(0, '0, '0, 0, '0, '0, 1, 0);
    for (int k = 0; k < 4; k++)
      step(1, OWN, mk('h600 + k, 0), 1, OWN, mk('h700 + k, 1), 0, 0);
    step(0, '0, '0, 0, '0, '0, 0, 1);
    check("pre_rst_queued", occ, 3);
    @(negedge clk);
    #1;
    rst = 1'b1;
    bus.i_a_valid = 1'b0; bus.i_b_valid = 1'b0; i_bcast_done = 1'b0;
    exp_q.delete();
    mdl_active = 0; occ = 0;
    @(negedge clk);
    check("midrst_wr_en", bus.o_wr_en, 1'b0);
    check("midrst_working", o_working, 1'b0);
    check("midrst_count", o_wr_count, '0);
    #1 rst = 1'b0;
    begin
      bit pulsed = 0;
      for (int k = 0; k < 8; k++) begin
        step(0, '0, '0, 0, '0, '0, 0, (k == 0));
        if (o_drained === 1'b1) pulsed = 1;
      end
      check("midrst_no_drain", pulsed, 1'b0);
    end
    step(0, '0, '0, 1, OWN, mk(1, 1), 0, 0);
    idle();
    check("midrst_idle_stray", o_stray, exp_stray);
    check("midrst_sb_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
